// File: rtl/iq_seq_pkg.sv
// Shared types and default sizing for the I/Q playback sequencer.
package iq_seq_pkg;

    // Run control: PLAY issues table reads, FLUSH lets the last read drain.
    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StFlush
    } seq_state_t;

    localparam int unsigned ADDR_W_DEFAULT    = 13;
    localparam int unsigned SAMPLE_W_DEFAULT  = 2;
    localparam int unsigned LOOP_W_DEFAULT    = 16;
    localparam int unsigned IDLE_CODE_DEFAULT = 1;

endpackage

// File: rtl/iq_sample_ram.sv
// Simple dual-port sample table: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module iq_sample_ram #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: commit on the clock edge when enabled.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: synchronous, returns the pre-write contents on a collision.
    always_ff @(posedge clock) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/iq_playback_sequencer.sv
// Plays addresses 0..end_addr of the I/Q sample table to the DAC outputs,
// loop_count passes (0 = until stopped). Reads take one clock, the output
// register another, so sample n appears 2+n clocks after the start edge.
module iq_playback_sequencer
    import iq_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned SAMPLE_W  = SAMPLE_W_DEFAULT,
    parameter int unsigned LOOP_W    = LOOP_W_DEFAULT,
    parameter int unsigned IDLE_CODE = IDLE_CODE_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    input  logic [SAMPLE_W-1:0] wr_data_q,
    output logic                wr_reject,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic [LOOP_W-1:0]   loop_count,
    output logic [SAMPLE_W-1:0] out_i,
    output logic [SAMPLE_W-1:0] out_q,
    output logic                busy,
    output logic                done
);

    localparam logic [SAMPLE_W-1:0] IdleCode = SAMPLE_W'(IDLE_CODE);

    seq_state_t          state;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   end_addr_lat;
    logic [LOOP_W-1:0]   loops_lat;
    logic [LOOP_W-1:0]   pass;
    // Tags travelling alongside the read: data valid, and final sample of the run.
    logic                rd_valid;
    logic                rd_last;
    logic                out_last;
    logic                wr_accept;
    logic                abort;
    logic [2*SAMPLE_W-1:0] ram_rd_data;

    // Table is host-writable only while no run is active.
    assign wr_accept = wr_en && (state == StIdle);
    assign abort     = stop && (state != StIdle);

    iq_sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (2 * SAMPLE_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr),
        .wr_data ({wr_data_i, wr_data_q}),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Run FSM with address/pass counters, busy and write-reject flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            rd_addr      <= '0;
            end_addr_lat <= '0;
            loops_lat    <= '0;
            pass         <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            busy         <= 1'b0;
            wr_reject    <= 1'b0;
        end else begin
            wr_reject <= wr_en && (state != StIdle);
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !stop) begin
                        state        <= StPlay;
                        busy         <= 1'b1;
                        end_addr_lat <= end_addr;
                        loops_lat    <= loop_count;
                        rd_addr      <= '0;
                        pass         <= '0;
                    end
                end
                StPlay: begin
                    if (stop) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        rd_valid <= 1'b1;
                        if (rd_addr == end_addr_lat) begin
                            rd_addr <= '0;
                            // Infinite runs let the pass counter wrap freely.
                            pass    <= pass + LOOP_W'(1);
                            if ((loops_lat != '0) && (pass == loops_lat - LOOP_W'(1))) begin
                                state   <= StFlush;
                                rd_last <= 1'b1;
                            end
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                StFlush: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: present read data, else mid-scale; done trails the last sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_i    <= IdleCode;
            out_q    <= IdleCode;
            out_last <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            out_i    <= IdleCode;
            out_q    <= IdleCode;
            out_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (rd_valid) begin
                out_i <= ram_rd_data[2*SAMPLE_W-1:SAMPLE_W];
                out_q <= ram_rd_data[SAMPLE_W-1:0];
            end else begin
                out_i <= IdleCode;
                out_q <= IdleCode;
            end
            out_last <= rd_last;
            done     <= out_last;
        end
    end

endmodule

// File: tb/tb_iq_playback_sequencer.sv
// Bench for iq_playback_sequencer: directed and randomized runs checked
// against a per-cycle model derived from the playback timing rules.
module tb_iq_playback_sequencer;

    localparam int ADDR_W = 13;
    localparam int IDLE   = 5; // {I=1, Q=1}

    logic                clock = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [1:0]          wr_data_i;
    logic [1:0]          wr_data_q;
    logic                wr_reject;
    logic                start;
    logic                stop;
    logic [ADDR_W-1:0]   end_addr;
    logic [15:0]         loop_count;
    logic [1:0]          out_i;
    logic [1:0]          out_q;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;
    int tbl [16];

    iq_playback_sequencer u_dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data_i  (wr_data_i),
        .wr_data_q  (wr_data_q),
        .wr_reject  (wr_reject),
        .start      (start),
        .stop       (stop),
        .end_addr   (end_addr),
        .loop_count (loop_count),
        .out_i      (out_i),
        .out_q      (out_q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_out, input int e_busy,
                           input int e_done, input int e_rej);
        chk({tag, " out"}, int'({out_i, out_q}), e_out);
        chk({tag, " busy"}, int'(busy), e_busy);
        chk({tag, " done"}, int'(done), e_done);
        chk({tag, " wr_reject"}, int'(wr_reject), e_rej);
    endtask

    task automatic load(input int a, input int v);
        wr_en     = 1'b1;
        wr_addr   = ADDR_W'(a);
        wr_data_i = 2'(v >> 2);
        wr_data_q = 2'(v);
        @(posedge clock); #2;
        wr_en = 1'b0;
        tbl[a] = v & 15;
        chk("load wr_reject", int'(wr_reject), 0);
    endtask

    // One run from a start edge (k = 0). stop_at / wr_at: edge index at which
    // stop / a refused write is sampled (-1 = none). hold: extra edges start stays
    // high. co_addr: address written on the start edge itself (-1 = none).
    task automatic run(input int e, input int loops, input int stop_at, input int wr_at,
                       input int hold, input int co_addr, input string name);
        int n;
        int last;
        int e_out;
        int e_busy;
        int e_done;
        bit stopped;
        n    = (loops == 0) ? 1000000 : (e + 1) * loops;
        last = (stop_at >= 0) ? stop_at + 2 : n + 3;
        end_addr   = ADDR_W'(e);
        loop_count = 16'(loops);
        start      = 1'b1;
        stop       = 1'b0;
        if (co_addr >= 0) begin
            wr_en     = 1'b1;
            wr_addr   = ADDR_W'(co_addr);
            wr_data_i = 2'($urandom_range(0, 3));
            wr_data_q = 2'($urandom_range(0, 3));
            tbl[co_addr] = int'({wr_data_i, wr_data_q});
        end
        for (int k = 0; k <= last; k++) begin
            @(posedge clock); #2;
            stopped = (stop_at >= 0) && (k >= stop_at);
            if (stopped) begin
                e_out  = IDLE;
                e_busy = 0;
                e_done = 0;
            end else begin
                e_busy = (k <= n) ? 1 : 0;
                e_done = (k == n + 2) ? 1 : 0;
                e_out  = (k >= 2 && k - 2 < n) ? tbl[(k - 2) % (e + 1)] : IDLE;
            end
            chk_all($sformatf("%s k=%0d", name, k), e_out, e_busy, e_done, (k == wr_at) ? 1 : 0);
            start = (k + 1 <= hold) ? 1'b1 : 1'b0;
            stop  = (k + 1 == stop_at) ? 1'b1 : 1'b0;
            wr_en = (k + 1 == wr_at) ? 1'b1 : 1'b0;
            if (k + 1 == wr_at) begin
                // Refused write of a different value to address 2.
                wr_addr   = ADDR_W'(2);
                wr_data_i = 2'(~(tbl[2] >> 2));
                wr_data_q = 2'(~tbl[2]);
            end
            if (k == 0) begin
                // Latched at start: later changes must not matter.
                end_addr   = ADDR_W'($urandom_range(0, 15));
                loop_count = 16'($urandom_range(0, 7));
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data_i  = '0;
        wr_data_q  = '0;
        start      = 1'b0;
        stop       = 1'b0;
        end_addr   = '0;
        loop_count = '0;
        #12;
        chk_all("in reset", IDLE, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #2;
        chk_all("after reset", IDLE, 0, 0, 0);

        // Basic two-pass playback of a four-entry table.
        load(0, 4'b0001);
        load(1, 4'b0110);
        load(2, 4'b1011);
        load(3, 4'b1110);
        run(3, 2, -1, -1, 0, -1, "t1");

        // Single-sample table, three passes.
        run(0, 3, -1, -1, 0, -1, "t2");

        // Randomized tables and run shapes.
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 8; a++) begin
                load(a, int'($urandom_range(0, 15)));
            end
            run(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), -1, -1, 0, -1,
                $sformatf("rnd%0d", r));
        end

        // Infinite run, stopped after 20 play cycles.
        run(5, 0, 21, -1, 0, -1, "t3");

        // Refused write mid-run: table must still play the old address 2 value.
        run(3, 2, -1, 2, 0, -1, "t4");
        run(3, 1, -1, -1, 0, -1, "t4b");

        // start+stop together while idle: no run.
        start = 1'b1;
        stop  = 1'b1;
        end_addr   = ADDR_W'(3);
        loop_count = 16'd1;
        @(posedge clock); #2;
        start = 1'b0;
        stop  = 1'b0;
        chk_all("t5 start+stop", IDLE, 0, 0, 0);
        @(posedge clock); #2;
        chk_all("t5 still idle", IDLE, 0, 0, 0);

        // start held high while busy must not restart the sequence.
        run(3, 2, -1, -1, 4, -1, "t5 hold");

        // Stop sampled in the flush cycle suppresses the final sample and done.
        run(2, 1, 4, -1, 0, -1, "t5 flushstop");

        // Write on the start edge lands before its address is read.
        run(2, 1, -1, -1, 0, 2, "t7 cowrite");

        // Asynchronous reset in the middle of an infinite run.
        end_addr   = ADDR_W'(3);
        loop_count = 16'd0;
        start      = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        chk("t6 busy before reset", int'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_all("t6 async reset", IDLE, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #2;
        chk_all("t6 post reset", IDLE, 0, 0, 0);
        for (int a = 0; a < 4; a++) begin
            load(a, int'($urandom_range(0, 15)));
        end
        run(3, 1, -1, -1, 0, -1, "t6 replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
